// File: rtl/pong_pkg.sv
// Shared types and constants for the pong ball engine: FSM states, direction
// encoding and the centre-of-field helper.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        SCORED = 2'd2
    } ball_state_t;

    // NEG is left on X and up on Y; POS is right on X and down on Y.
    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_t;

    function automatic int centre_of(input int extent, input int size);
        return (extent - size) / 2;
    endfunction

    localparam int DEF_CENTRE_X = centre_of(640, 8);
    localparam int DEF_CENTRE_Y = centre_of(480, 8);

endpackage

// File: rtl/rising_edge_pulse.sv
// One-clk pulse on each rising edge of a level that is already synchronous to clk.
module rising_edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pulse
);

    logic in_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign pulse = in & ~in_q;

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball motion: steps once per game tick, bounces off walls and paddles,
// reports paddle hits and misses, then holds after a point before recentring.
module pong_ball_engine
    import pong_pkg::*;
#(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int BALL_SIZE  = 8,
    parameter int STEP       = 1,
    parameter int PADDLE_W   = 8,
    parameter int PADDLE_H   = 64,
    parameter int PADDLE_X_L = 16,
    parameter int PADDLE_X_R = 616,
    parameter int HOLD_TICKS = 60,
    parameter int POS_W      = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_clk,
    input  logic             serve,
    input  logic [POS_W-1:0] paddle_l_y,
    input  logic [POS_W-1:0] paddle_r_y,
    output logic [POS_W-1:0] ball_x,
    output logic [POS_W-1:0] ball_y,
    output logic             ball_active,
    output logic             hit,
    output logic             score_l,
    output logic             score_r,
    output ball_state_t      dbg_state_o
);

    localparam int XW     = POS_W + 1;
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    localparam logic [XW-1:0]     STEP_E    = XW'(STEP);
    localparam logic [XW-1:0]     BALL_E    = XW'(BALL_SIZE);
    localparam logic [XW-1:0]     PAD_H_E   = XW'(PADDLE_H);
    localparam logic [XW-1:0]     Y_MAX_E   = XW'(SCREEN_H - BALL_SIZE);
    localparam logic [XW-1:0]     X_MAX_E   = XW'(SCREEN_W - BALL_SIZE);
    localparam logic [XW-1:0]     FACE_L_E  = XW'(PADDLE_X_L + PADDLE_W);
    localparam logic [XW-1:0]     FACE_R_E  = XW'(PADDLE_X_R - BALL_SIZE);
    localparam logic [POS_W-1:0]  CENTRE_X  = POS_W'(centre_of(SCREEN_W, BALL_SIZE));
    localparam logic [POS_W-1:0]  CENTRE_Y  = POS_W'(centre_of(SCREEN_H, BALL_SIZE));
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    ball_state_t       state_q;
    logic [POS_W-1:0]  x_q, y_q;
    dir_t              dx_q, dy_q, sdir_q;
    logic [HOLD_W-1:0] hold_q;
    logic              active_q, hit_q, score_l_q, score_r_q;

    logic              step_en;

    logic [XW-1:0]     x_e, y_e, pl_e, pr_e;
    logic [XW-1:0]     x_dec, x_inc, y_dec, y_inc;
    logic              ovl_l, ovl_r, cross_l, cross_r;
    logic [POS_W-1:0]  x_d, y_d;
    dir_t              dx_d, dy_d;
    logic              x_hit, miss_l, miss_r;

    rising_edge_pulse u_tick_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .in    (tick_clk),
        .pulse (step_en)
    );

    // Both axes are resolved from the pre-step position, one bit wider so
    // nothing wraps; paddle overlap therefore uses the old Y.
    always_comb begin
        x_e   = {1'b0, x_q};
        y_e   = {1'b0, y_q};
        pl_e  = {1'b0, paddle_l_y};
        pr_e  = {1'b0, paddle_r_y};
        x_dec = x_e - STEP_E;
        x_inc = x_e + STEP_E;
        y_dec = y_e - STEP_E;
        y_inc = y_e + STEP_E;

        ovl_l   = (y_e + BALL_E > pl_e) && (y_e < pl_e + PAD_H_E);
        ovl_r   = (y_e + BALL_E > pr_e) && (y_e < pr_e + PAD_H_E);
        cross_l = (x_e >= FACE_L_E) && (x_dec < FACE_L_E);
        cross_r = (x_e <= FACE_R_E) && (x_inc > FACE_R_E);

        y_d  = y_q;
        dy_d = dy_q;
        if (dy_q == DIR_NEG) begin
            if (y_e < STEP_E) begin
                y_d  = '0;
                dy_d = DIR_POS;
            end else begin
                y_d = POS_W'(y_dec);
            end
        end else begin
            if (y_inc > Y_MAX_E) begin
                y_d  = POS_W'(Y_MAX_E);
                dy_d = DIR_NEG;
            end else begin
                y_d = POS_W'(y_inc);
            end
        end

        x_d    = x_q;
        dx_d   = dx_q;
        x_hit  = 1'b0;
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (dx_q == DIR_NEG) begin
            if (cross_l && ovl_l) begin
                x_d   = POS_W'(FACE_L_E);
                dx_d  = DIR_POS;
                x_hit = 1'b1;
            end else if (x_e < STEP_E) begin
                miss_l = 1'b1;
            end else begin
                x_d = POS_W'(x_dec);
            end
        end else begin
            if (cross_r && ovl_r) begin
                x_d   = POS_W'(FACE_R_E);
                dx_d  = DIR_NEG;
                x_hit = 1'b1;
            end else if (x_inc > X_MAX_E) begin
                miss_r = 1'b1;
            end else begin
                x_d = POS_W'(x_inc);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            x_q       <= CENTRE_X;
            y_q       <= CENTRE_Y;
            dx_q      <= DIR_POS;
            dy_q      <= DIR_POS;
            sdir_q    <= DIR_POS;
            hold_q    <= '0;
            active_q  <= 1'b0;
            hit_q     <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            hit_q     <= 1'b0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // A coincident tick is deliberately ignored: the first move waits for the next step.
                    if (serve) begin
                        state_q  <= MOVING;
                        active_q <= 1'b1;
                        dx_q     <= sdir_q;
                        dy_q     <= DIR_POS;
                    end
                end
                MOVING: begin
                    if (step_en) begin
                        y_q  <= y_d;
                        dy_q <= dy_d;
                        if (miss_l || miss_r) begin
                            state_q   <= SCORED;
                            active_q  <= 1'b0;
                            score_r_q <= miss_l;
                            score_l_q <= miss_r;
                            sdir_q    <= miss_l ? DIR_NEG : DIR_POS;
                        end else begin
                            x_q   <= x_d;
                            dx_q  <= dx_d;
                            hit_q <= x_hit;
                        end
                    end
                end
                SCORED: begin
                    if (step_en) begin
                        if (hold_q == HOLD_LAST) begin
                            state_q <= IDLE;
                            hold_q  <= '0;
                            x_q     <= CENTRE_X;
                            y_q     <= CENTRE_Y;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ball_x      = x_q;
    assign ball_y      = y_q;
    assign ball_active = active_q;
    assign hit         = hit_q;
    assign score_l     = score_l_q;
    assign score_r     = score_r_q;
    assign dbg_state_o = state_q;

endmodule
